// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame width, bit-counter width, FSM encoding and
// bus idle levels (also used by spi_master).
package spi_pkg;

    localparam int SPI_WIDTH = 8;
    localparam int SPI_CTR_W = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

    localparam logic SPI_IDLE_SCK  = 1'b0;
    localparam logic SPI_IDLE_SS_N = 1'b1;
    localparam logic SPI_IDLE_MISO = 1'b0;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous bus pin. The reset value is
// an input so each pin can come out of reset at its own idle level.
module spi_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rst_val,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the pin through the flop chain; reset to the idle level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain <= {STAGES{rst_val}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI target, mode 0, MSB first, 8-bit frames, oversampled on clk.
// Optional: define SPI_SLAVE_FRAME_ERR_EN to add the frame_err pulse output
// (abort mid-frame, or SCK rising too soon after SS_N falls).
// Handshake: tx_load is a one-cycle write strobe into a single-entry buffer
// (always accepted, overwrites); new_data is a one-cycle pulse, no backpressure.
module spi_slave
    import spi_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic IDLE_MISO   = SPI_IDLE_MISO
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ss_n,
    input  logic                 sck,
    input  logic                 mosi,
    output logic                 miso,
    input  logic [SPI_WIDTH-1:0] tx_data,
    input  logic                 tx_load,
    output logic                 tx_pending,
    output logic [SPI_WIDTH-1:0] data_out,
    output logic                 new_data,
    output logic                 busy
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    output logic                 frame_err
`endif
);

    logic sck_s, ss_n_s, mosi_s;
    logic sck_d, ss_n_d;
    logic sck_rise, sck_fall, ss_fall;

    spi_state_e state_q, state_d;

    logic [SPI_CTR_W-1:0] ctr;
    logic [SPI_WIDTH-2:0] rx_shift;
    logic [SPI_WIDTH-1:0] tx_shift;
    logic [SPI_WIDTH-1:0] tx_buf;
    logic                 reload;
    logic                 run;
    logic                 abort;

    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (
        .clk(clk), .rst(rst), .rst_val(SPI_IDLE_SCK), .d(sck), .q(sck_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_ss_n (
        .clk(clk), .rst(rst), .rst_val(SPI_IDLE_SS_N), .d(ss_n), .q(ss_n_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .rst(rst), .rst_val(1'b0), .d(mosi), .q(mosi_s)
    );

    // Previous synchronized samples for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sck_d  <= SPI_IDLE_SCK;
            ss_n_d <= SPI_IDLE_SS_N;
        end else begin
            sck_d  <= sck_s;
            ss_n_d <= ss_n_s;
        end
    end

    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign ss_fall  = ss_n_d & ~ss_n_s;
    assign run      = (state_q == ACTIVE) && !ss_n_s;
    assign abort    = (state_q == ACTIVE) && ss_n_s && (ctr != '0);
    // Shifter takes the buffer at select and at each byte boundary.
    assign reload   = ((state_q == IDLE) && ss_fall) ||
                      (run && sck_fall && (ctr == '0));
    assign busy     = ~ss_n_s;

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // FSM next state and miso drive.
    always_comb begin
        state_d = state_q;
        miso    = IDLE_MISO;
        case (state_q)
            IDLE: begin
                if (ss_fall) state_d = ACTIVE;
            end
            ACTIVE: begin
                miso = tx_shift[SPI_WIDTH-1];
                if (ss_n_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Transmit buffer: tx_load wins over a same-cycle reload clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_buf     <= '0;
            tx_pending <= 1'b0;
        end else if (tx_load) begin
            tx_buf     <= tx_data;
            tx_pending <= 1'b1;
        end else if (reload) begin
            tx_pending <= 1'b0;
        end
    end

    // Shift datapath, bit counter and received-byte delivery.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctr      <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
            data_out <= '0;
            new_data <= 1'b0;
        end else begin
            new_data <= 1'b0;
            if (reload) begin
                tx_shift <= tx_buf;
            end else if (run && sck_fall) begin
                tx_shift <= {tx_shift[SPI_WIDTH-2:0], 1'b0};
            end
            if (!run) begin
                ctr      <= '0;
                rx_shift <= '0;
            end else if (sck_rise) begin
                rx_shift <= {rx_shift[SPI_WIDTH-3:0], mosi_s};
                ctr      <= ctr + 1'b1;
                if (ctr == '1) begin
                    data_out <= {rx_shift, mosi_s};
                    new_data <= 1'b1;
                end
            end
        end
    end

`ifdef SPI_SLAVE_FRAME_ERR_EN
    localparam int SW = $clog2(SYNC_STAGES + 1);
    logic [SW-1:0] setup_cnt;

    // Setup window after select, and a one-cycle error pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            setup_cnt <= '0;
            frame_err <= 1'b0;
        end else begin
            if (ss_fall)                setup_cnt <= SW'(SYNC_STAGES);
            else if (setup_cnt != '0)   setup_cnt <= setup_cnt - 1'b1;
            frame_err <= abort || (run && sck_rise && (setup_cnt != '0));
        end
    end
`else
    // Aborts are silent in this build.
    logic unused_abort;
    assign unused_abort = abort;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: drives SPI mode-0 frames as the master and
// checks miso, received bytes, new_data pulses and tx buffer status.
module tb_spi_slave;

    localparam int HALF = 6;   // clk cycles per SCK phase

    logic       clk;
    logic       rst;
    logic       ss_n;
    logic       sck;
    logic       mosi;
    logic       miso;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_pending;
    logic [7:0] data_out;
    logic       new_data;
    logic       busy;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic       frame_err;
    int         fe_cnt = 0;
`endif

    int tests  = 0;
    int fails  = 0;
    int nd_cnt = 0;

    spi_slave #(.SYNC_STAGES(2), .IDLE_MISO(1'b0)) dut (
        .clk(clk), .rst(rst), .ss_n(ss_n), .sck(sck), .mosi(mosi),
        .miso(miso), .tx_data(tx_data), .tx_load(tx_load),
        .tx_pending(tx_pending), .data_out(data_out),
        .new_data(new_data), .busy(busy)
`ifdef SPI_SLAVE_FRAME_ERR_EN
        , .frame_err(frame_err)
`endif
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters, sampled away from the active edge
    always @(negedge clk) begin
        if (new_data === 1'b1) nd_cnt <= nd_cnt + 1;
`ifdef SPI_SLAVE_FRAME_ERR_EN
        if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
`endif
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_tx(input logic [7:0] b);
        @(negedge clk);
        tx_data = b;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    // Master shifts nbits of mo out MSB first, collecting miso before each rise
    task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = mo[7-i];
            wait_cyc(HALF);
            mi[7-i] = miso;
            sck = 1'b1;
            wait_cyc(HALF);
            sck = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; ss_n = 1'b1; sck = 1'b0; mosi = 1'b0;
        tx_data = 8'h00; tx_load = 1'b0;
        wait_cyc(3);
        tests++; if (miso !== 1'b0) begin fails++; $display("FAIL reset_miso got=%b exp=0", miso); end
        tests++; if (tx_pending !== 1'b0) begin fails++; $display("FAIL reset_pending got=%b exp=0", tx_pending); end
        tests++; if (data_out !== 8'h00) begin fails++; $display("FAIL reset_data got=%h exp=00", data_out); end
        tests++; if (new_data !== 1'b0) begin fails++; $display("FAIL reset_new_data got=%b exp=0", new_data); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst = 1'b1;
        wait_cyc(4);
    endtask

    task automatic test_basic();
        logic [7:0] mi;
        int n0;
        load_tx(8'hA5);
        tests++; if (tx_pending !== 1'b1) begin fails++; $display("FAIL basic_pending_set got=%b exp=1", tx_pending); end
        n0 = nd_cnt;
        ss_n = 1'b0;
        wait_cyc(HALF);
        tests++; if (tx_pending !== 1'b0) begin fails++; $display("FAIL basic_pending_clr got=%b exp=0", tx_pending); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy got=%b exp=1", busy); end
        xfer(8'h3C, 8, mi);
        wait_cyc(HALF);
        ss_n = 1'b1;
        wait_cyc(HALF);
        tests++; if (mi !== 8'hA5) begin fails++; $display("FAIL basic_miso got=%h exp=a5", mi); end
        tests++; if (data_out !== 8'h3C) begin fails++; $display("FAIL basic_data got=%h exp=3c", data_out); end
        tests++; if (nd_cnt - n0 !== 1) begin fails++; $display("FAIL basic_pulses got=%0d exp=1", nd_cnt - n0); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_off got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] mi1, mi2;
        int n0;
        n0 = nd_cnt;
        ss_n = 1'b0;
        wait_cyc(HALF);
        load_tx(8'h81);
        tests++; if (tx_pending !== 1'b1) begin fails++; $display("FAIL b2b_pending_set got=%b exp=1", tx_pending); end
        xfer(8'hFF, 8, mi1);
        wait_cyc(HALF);
        tests++; if (data_out !== 8'hFF) begin fails++; $display("FAIL b2b_data1 got=%h exp=ff", data_out); end
        tests++; if (tx_pending !== 1'b0) begin fails++; $display("FAIL b2b_pending_clr got=%b exp=0", tx_pending); end
        tests++; if (mi1 !== 8'hA5) begin fails++; $display("FAIL b2b_miso1 got=%h exp=a5", mi1); end
        xfer(8'h00, 8, mi2);
        wait_cyc(HALF);
        ss_n = 1'b1;
        wait_cyc(HALF);
        tests++; if (mi2 !== 8'h81) begin fails++; $display("FAIL b2b_miso2 got=%h exp=81", mi2); end
        tests++; if (data_out !== 8'h00) begin fails++; $display("FAIL b2b_data2 got=%h exp=00", data_out); end
        tests++; if (nd_cnt - n0 !== 2) begin fails++; $display("FAIL b2b_pulses got=%0d exp=2", nd_cnt - n0); end
    endtask

    task automatic test_abort();
        logic [7:0] mi;
        int n0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
        int f0;
        f0 = fe_cnt;
`endif
        n0 = nd_cnt;
        ss_n = 1'b0;
        wait_cyc(HALF);
        xfer(8'hFF, 5, mi);
        ss_n = 1'b1;
        wait_cyc(2 * HALF);
        tests++; if (nd_cnt - n0 !== 0) begin fails++; $display("FAIL abort_pulses got=%0d exp=0", nd_cnt - n0); end
        tests++; if (data_out !== 8'h00) begin fails++; $display("FAIL abort_data got=%h exp=00", data_out); end
`ifdef SPI_SLAVE_FRAME_ERR_EN
        tests++; if (fe_cnt - f0 !== 1) begin fails++; $display("FAIL abort_frame_err got=%0d exp=1", fe_cnt - f0); end
`endif
        ss_n = 1'b0;
        wait_cyc(HALF);
        xfer(8'h5A, 8, mi);
        wait_cyc(HALF);
        ss_n = 1'b1;
        wait_cyc(HALF);
        tests++; if (data_out !== 8'h5A) begin fails++; $display("FAIL abort_next_data got=%h exp=5a", data_out); end
        tests++; if (nd_cnt - n0 !== 1) begin fails++; $display("FAIL abort_next_pulses got=%0d exp=1", nd_cnt - n0); end
        tests++; if (mi !== 8'h81) begin fails++; $display("FAIL abort_next_miso got=%h exp=81", mi); end
    endtask

    task automatic test_stale();
        logic [7:0] mi;
        load_tx(8'hC3);
        ss_n = 1'b0;
        wait_cyc(HALF);
        xfer(8'h11, 8, mi);
        wait_cyc(HALF);
        ss_n = 1'b1;
        wait_cyc(HALF);
        tests++; if (mi !== 8'hC3) begin fails++; $display("FAIL stale_first got=%h exp=c3", mi); end
        ss_n = 1'b0;
        wait_cyc(HALF);
        tests++; if (tx_pending !== 1'b0) begin fails++; $display("FAIL stale_pending got=%b exp=0", tx_pending); end
        xfer(8'h22, 8, mi);
        wait_cyc(HALF);
        ss_n = 1'b1;
        wait_cyc(HALF);
        tests++; if (mi !== 8'hC3) begin fails++; $display("FAIL stale_resend got=%h exp=c3", mi); end
        tests++; if (data_out !== 8'h22) begin fails++; $display("FAIL stale_data got=%h exp=22", data_out); end
    endtask

    task automatic test_idle_sck();
        logic [7:0] mi;
        int n0;
        n0 = nd_cnt;
        xfer(8'hFF, 8, mi);
        wait_cyc(HALF);
        tests++; if (mi !== 8'h00) begin fails++; $display("FAIL idle_miso got=%h exp=00", mi); end
        tests++; if (nd_cnt - n0 !== 0) begin fails++; $display("FAIL idle_pulses got=%0d exp=0", nd_cnt - n0); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy got=%b exp=0", busy); end
        tests++; if (data_out !== 8'h22) begin fails++; $display("FAIL idle_data got=%h exp=22", data_out); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] mi;
        int n0;
        load_tx(8'h77);
        ss_n = 1'b0;
        wait_cyc(HALF);
        xfer(8'hFF, 3, mi);
        #2;
        rst = 1'b0;
        #1;
        tests++; if (miso !== 1'b0) begin fails++; $display("FAIL rstmid_miso got=%b exp=0", miso); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        tests++; if (data_out !== 8'h00) begin fails++; $display("FAIL rstmid_data got=%h exp=00", data_out); end
        tests++; if (tx_pending !== 1'b0) begin fails++; $display("FAIL rstmid_pending got=%b exp=0", tx_pending); end
        tests++; if (new_data !== 1'b0) begin fails++; $display("FAIL rstmid_new_data got=%b exp=0", new_data); end
        ss_n = 1'b1; sck = 1'b0; mosi = 1'b0;
        wait_cyc(3);
        rst = 1'b1;
        wait_cyc(4);
        n0 = nd_cnt;
        ss_n = 1'b0;
        wait_cyc(HALF);
        xfer(8'h96, 8, mi);
        wait_cyc(HALF);
        ss_n = 1'b1;
        wait_cyc(HALF);
        tests++; if (data_out !== 8'h96) begin fails++; $display("FAIL rstmid_next_data got=%h exp=96", data_out); end
        tests++; if (nd_cnt - n0 !== 1) begin fails++; $display("FAIL rstmid_next_pulses got=%0d exp=1", nd_cnt - n0); end
        tests++; if (mi !== 8'h00) begin fails++; $display("FAIL rstmid_next_miso got=%h exp=00", mi); end
    endtask

    // Test sequence and final report
    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_abort();
        test_stale();
        test_idle_sck();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
